// File: rtl/oric_ram_arbiter.sv
// Main-RAM port arbiter: clear sweep, never-stalled CPU/video bus, and tape
// loader writes slotted into CPU-idle cycles through a req/ack handshake.
module oric_ram_arbiter #(
    parameter int          AW   = 16,
    parameter logic [7:0]  FILL = 8'hFF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear_req,
    output logic          clear_busy,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    input  logic          tape_req,
    input  logic [AW-1:0] tape_addr,
    input  logic [7:0]    tape_d,
    output logic          tape_ack,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_d,
    input  logic [7:0]    mem_q
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          mem_ce_q, mem_ce_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_d_q, mem_d_d;
    logic          tape_ack_q, tape_ack_d;
    logic          clear_busy_q, clear_busy_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_d_q      <= '0;
            tape_ack_q   <= 1'b0;
            clear_busy_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_ce_q     <= mem_ce_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_d_q      <= mem_d_d;
            tape_ack_q   <= tape_ack_d;
            clear_busy_q <= clear_busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                if (clear_req) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                    if (&cnt_q) begin
                        state_d = S_SERVE;
                    end
                end
            end
            S_SERVE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // A restart edge (clear_req) issues no access; the sweep begins on the next edge.
    always_comb begin
        mem_ce_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_d_d      = mem_d_q;
        tape_ack_d   = 1'b0;
        clear_busy_d = (state_d == S_CLEAR);
        case (state_q)
            S_CLEAR: begin
                if (!clear_req) begin
                    mem_ce_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = cnt_q;
                    mem_d_d    = FILL;
                end
            end
            S_SERVE: begin
                if (!clear_req) begin
                    if (cpu_cs) begin
                        mem_ce_d   = 1'b1;
                        mem_we_d   = cpu_we;
                        mem_addr_d = cpu_addr;
                        mem_d_d    = cpu_d;
                    end else if (tape_req && !tape_ack_q) begin
                        // tape_ack_q gate keeps one held request from writing twice
                        mem_ce_d   = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = tape_addr;
                        mem_d_d    = tape_d;
                        tape_ack_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign mem_ce     = mem_ce_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_d      = mem_d_q;
    assign tape_ack   = tape_ack_q;
    assign clear_busy = clear_busy_q;
    assign cpu_q      = mem_q;

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Bench for oric_ram_arbiter: a 4-bit-address instance for sweep, clear and reset
// behaviour, and a 13-bit-address instance for CPU and tape traffic.
module tb_oric_ram_arbiter;

    localparam int AS = 4;
    localparam int AB = 13;

    logic clk;
    int   n_chk;
    int   n_err;

    logic [7:0]  rd_q [$];
    logic [11:0] ts_q [$];
    logic [20:0] tb_q [$];

    // small instance
    logic          s_rst_n, s_clear_req, s_clear_busy;
    logic          s_cpu_cs, s_cpu_we;
    logic [AS-1:0] s_cpu_addr;
    logic [7:0]    s_cpu_d, s_cpu_q;
    logic          s_tape_req, s_tape_ack;
    logic [AS-1:0] s_tape_addr;
    logic [7:0]    s_tape_d;
    logic          s_mem_ce, s_mem_we;
    logic [AS-1:0] s_mem_addr;
    logic [7:0]    s_mem_d, s_mem_q;
    logic [7:0]    ram_s [0:(1<<AS)-1];

    // big instance
    logic          b_rst_n, b_clear_req, b_clear_busy;
    logic          b_cpu_cs, b_cpu_we;
    logic [AB-1:0] b_cpu_addr;
    logic [7:0]    b_cpu_d, b_cpu_q;
    logic          b_tape_req, b_tape_ack;
    logic [AB-1:0] b_tape_addr;
    logic [7:0]    b_tape_d;
    logic          b_mem_ce, b_mem_we;
    logic [AB-1:0] b_mem_addr;
    logic [7:0]    b_mem_d, b_mem_q;
    logic [7:0]    ram_b [0:(1<<AB)-1];

    oric_ram_arbiter #(.AW(AS), .FILL(8'hFF)) u_small (
        .clk(clk), .reset_n(s_rst_n), .clear_req(s_clear_req), .clear_busy(s_clear_busy),
        .cpu_cs(s_cpu_cs), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_d(s_cpu_d),
        .cpu_q(s_cpu_q), .tape_req(s_tape_req), .tape_addr(s_tape_addr), .tape_d(s_tape_d),
        .tape_ack(s_tape_ack), .mem_ce(s_mem_ce), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_d(s_mem_d), .mem_q(s_mem_q)
    );

    oric_ram_arbiter #(.AW(AB), .FILL(8'hFF)) u_big (
        .clk(clk), .reset_n(b_rst_n), .clear_req(b_clear_req), .clear_busy(b_clear_busy),
        .cpu_cs(b_cpu_cs), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_d(b_cpu_d),
        .cpu_q(b_cpu_q), .tape_req(b_tape_req), .tape_addr(b_tape_addr), .tape_d(b_tape_d),
        .tape_ack(b_tape_ack), .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_d(b_mem_d), .mem_q(b_mem_q)
    );

    // clock / RAM models (registered read, port 1)
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (s_mem_ce) begin
            if (s_mem_we) ram_s[s_mem_addr] <= s_mem_d;
            s_mem_q <= ram_s[s_mem_addr];
        end
        if (b_mem_ce) begin
            if (b_mem_we) ram_b[b_mem_addr] <= b_mem_d;
            b_mem_q <= ram_b[b_mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int acks;
        int bad;
        int guard;
        int j;
        logic [11:0] es;
        logic [20:0] eb;
        logic [7:0]  er;

        n_chk = 0;
        n_err = 0;
        s_rst_n = 1'b0; s_clear_req = 1'b0; s_cpu_cs = 1'b0; s_cpu_we = 1'b0;
        s_cpu_addr = '0; s_cpu_d = '0; s_tape_req = 1'b0; s_tape_addr = '0; s_tape_d = '0;
        b_rst_n = 1'b0; b_clear_req = 1'b0; b_cpu_cs = 1'b0; b_cpu_we = 1'b0;
        b_cpu_addr = '0; b_cpu_d = '0; b_tape_req = 1'b0; b_tape_addr = '0; b_tape_d = '0;

        // reset state
        step(); step(); step();
        chk("rst_mem", 32'({s_mem_ce, s_mem_we, s_mem_addr, s_mem_d}), 32'd0);
        chk("rst_flags", 32'({s_tape_ack, s_clear_busy}), 32'b01);
        chk("rst_big", 32'({b_mem_ce, b_tape_ack, b_clear_busy}), 32'b001);
        s_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // power-on sweep: 16 writes of FF on consecutive edges
        for (int i = 0; i < 16; i++) begin
            step();
            chk("sweep_wr", 32'({s_mem_ce, s_mem_we, s_mem_addr, s_mem_d}), 32'({2'b11, 4'(i), 8'hFF}));
            chk("sweep_busy", 32'(s_clear_busy), 32'(i != 15));
        end

        // CPU read of address 5, data two edges later
        s_cpu_cs = 1'b1; s_cpu_we = 1'b0; s_cpu_addr = 4'd5;
        rd_q.push_back(8'hFF);
        step();
        chk("s_rd_issue", 32'({s_mem_ce, s_mem_we, s_mem_addr}), 32'({2'b10, 4'd5}));
        s_cpu_cs = 1'b0;
        step();
        er = rd_q.pop_front();
        chk("s_rd_data", 32'(s_cpu_q), 32'(er));
        bad = 0;
        for (int i = 0; i < 16; i++) if (ram_s[i] !== 8'hFF) bad++;
        chk("s_ram_fill", 32'(bad), 32'd0);

        // clear_req while a tape request is pending
        s_tape_req = 1'b1; s_tape_addr = 4'd3; s_tape_d = 8'h3C;
        ts_q.push_back({4'd3, 8'h3C});
        s_clear_req = 1'b1;
        step();
        s_clear_req = 1'b0;
        chk("clr_enter", 32'({s_clear_busy, s_mem_ce, s_tape_ack}), 32'b100);
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (s_tape_ack) acks++;
            chk("clr_wr", 32'({s_mem_ce, s_mem_we, s_mem_addr, s_mem_d}), 32'({2'b11, 4'(i), 8'hFF}));
        end
        chk("clr_no_ack", 32'(acks), 32'd0);
        chk("clr_done", 32'(s_clear_busy), 32'd0);
        step();
        chk("s_tape_ack", 32'(s_tape_ack), 32'd1);
        es = ts_q.pop_front();
        chk("s_tape_wr", 32'({s_mem_ce, s_mem_we, s_mem_addr, s_mem_d}), 32'({2'b11, es}));
        s_tape_req = 1'b0;
        step();
        chk("s_tape_idle", 32'({s_tape_ack, s_mem_ce, s_mem_addr}), 32'({2'b00, 4'd3}));
        chk("s_tape_ram", 32'(ram_s[3]), 32'h3C);

        // reset asserted mid-sweep with counter = 7
        s_clear_req = 1'b1;
        step();
        s_clear_req = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("mid_addr", 32'(s_mem_addr), 32'd6);
        #2 s_rst_n = 1'b0;
        #1;
        chk("mid_rst_mem", 32'({s_mem_ce, s_mem_we, s_mem_addr, s_mem_d}), 32'd0);
        chk("mid_rst_flags", 32'({s_tape_ack, s_clear_busy}), 32'b01);
        #1 s_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("restart_wr", 32'({s_mem_ce, s_mem_we, s_mem_addr, s_mem_d}), 32'({2'b11, 4'(i), 8'hFF}));
        end
        chk("restart_done", 32'(s_clear_busy), 32'd0);

        // big instance: wait for its sweep to finish
        guard = 0;
        while (b_clear_busy && guard < 9000) begin
            step();
            guard++;
        end
        chk("big_sweep_done", 32'(b_clear_busy), 32'd0);
        step();
        bad = 0;
        for (int i = 0; i < (1 << AB); i++) if (ram_b[i] !== 8'hFF) bad++;
        chk("b_ram_fill", 32'(bad), 32'd0);

        // CPU write then read of 0x1234
        b_cpu_cs = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 13'h1234; b_cpu_d = 8'h5A;
        step();
        chk("b_cpu_wr", 32'({b_mem_ce, b_mem_we, b_mem_addr, b_mem_d}), 32'({2'b11, 13'h1234, 8'h5A}));
        b_cpu_we = 1'b0; b_cpu_d = 8'h00;
        rd_q.push_back(8'h5A);
        step();
        chk("b_cpu_rd", 32'({b_mem_ce, b_mem_we, b_mem_addr}), 32'({2'b10, 13'h1234}));
        b_cpu_cs = 1'b0;
        step();
        er = rd_q.pop_front();
        chk("b_rd_data", 32'(b_cpu_q), 32'(er));

        // tape request blocked by 5 CPU cycles
        b_tape_req = 1'b1; b_tape_addr = 13'h0501; b_tape_d = 8'hA5;
        tb_q.push_back({13'h0501, 8'hA5});
        b_cpu_cs = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 13'h0100;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (b_tape_ack) acks++;
            chk("blk_cpu_addr", 32'(b_mem_addr), 32'h0100);
        end
        chk("blk_no_ack", 32'(acks), 32'd0);
        b_cpu_cs = 1'b0;
        step();
        chk("blk_ack", 32'(b_tape_ack), 32'd1);
        eb = tb_q.pop_front();
        chk("blk_tape_wr", 32'({b_mem_ce, b_mem_we, b_mem_addr, b_mem_d}), 32'({2'b11, eb}));
        b_tape_req = 1'b0;
        step();
        chk("blk_ack_drop", 32'(b_tape_ack), 32'd0);
        chk("blk_ram", 32'(ram_b[13'h0501]), 32'hA5);

        // 4-byte tape stream, CPU idle
        j = 0;
        acks = 0;
        b_tape_req = 1'b1; b_tape_addr = 13'h0600; b_tape_d = 8'h11;
        tb_q.push_back({13'h0600, 8'h11});
        for (int s = 1; s <= 10; s++) begin
            step();
            chk("stream_ack", 32'(b_tape_ack), 32'((s % 2 == 1) && (s <= 7)));
            if (b_tape_ack) begin
                acks++;
                eb = tb_q.pop_front();
                chk("stream_wr", 32'({b_mem_ce, b_mem_we, b_mem_addr, b_mem_d}), 32'({2'b11, eb}));
                j++;
                if (j < 4) begin
                    b_tape_addr = 13'h0600 + 13'(j);
                    b_tape_d    = 8'h11 + 8'(j * 8'h22);
                    tb_q.push_back({b_tape_addr, b_tape_d});
                end else begin
                    b_tape_req = 1'b0;
                end
            end
        end
        chk("stream_acks", 32'(acks), 32'd4);
        chk("stream_q_empty", 32'(tb_q.size()), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("stream_ram", 32'(ram_b[13'h0600 + 13'(k)]), 32'(8'h11 + 8'(k * 8'h22)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/oric_ram_arbiter.md
Name: oric_ram_arbiter

Overview:
- Owns the single 64 KB main-RAM port (registered-read dual-port RAM, port 1) and shares it between three sources: the power-on/explicit clear sweep, the oricatmos CPU/video bus, and the cassette tape loader.
- The tape loader writes decoded tape bytes into RAM through CPU-idle slots using a req/ack handshake. This replaces the separate tape write port.
- The CPU is never stalled.

Parameters:
- AW, 16, RAM address width; the clear sweep covers 0 .. 2^AW-1.
- FILL, 8'hFF, byte written to every location during a clear sweep.

Ports:
- clk  in  1  system clock (48 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- clear_req  in  1  single-cycle pulse; starts or restarts a clear sweep
- clear_busy  out  1  high while a clear sweep is in progress
- cpu_cs  in  1  CPU/video RAM select for this cycle
- cpu_we  in  1  CPU write enable, qualified by cpu_cs
- cpu_addr  in  AW  CPU address
- cpu_d  in  8  CPU write data
- cpu_q  out  8  CPU read data (wired from mem_q)
- tape_req  in  1  tape write request (level)
- tape_addr  in  AW  tape write address, held stable while tape_req is high
- tape_d  in  8  tape write data, held stable while tape_req is high
- tape_ack  out  1  one-cycle pulse: the tape write has been issued
- mem_ce  out  1  RAM chip enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  AW  RAM address (registered)
- mem_d  out  8  RAM write data (registered)
- mem_q  in  8  RAM registered read data

Behaviour:
- State machine has two states, CLEAR and SERVE. All mem_* outputs, tape_ack and clear_busy are registered.
- Reset (reset_n low, asynchronous):
  - state goes to CLEAR, clear counter = 0.
  - mem_ce=0, mem_we=0, mem_addr=0, mem_d=0, tape_ack=0, clear_busy=1.
- CLEAR:
  - On each clk edge: mem_ce=1, mem_we=1, mem_addr=counter, mem_d=FILL, then counter increments.
  - After the edge that issues address 2^AW-1: counter wraps to 0, state goes to SERVE, clear_busy goes to 0.
  - Total sweep is exactly 2^AW write cycles.
  - cpu_cs is ignored; cpu_q content is don't-care during CLEAR.
  - tape_ack stays 0; tape_req stays pending and is served after the sweep.
  - clear_req during CLEAR resets the counter to 0 (sweep restarts, clear_busy stays 1).
- SERVE, priority evaluated each edge:
  1. clear_req=1: enter CLEAR with counter 0. The first clear write is issued on the next edge. clear_busy=1 from this edge. No CPU or tape access is issued this edge.
  2. cpu_cs=1: mem_ce=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_d=cpu_d. tape_ack=0.
  3. cpu_cs=0 and tape_req=1 and tape_ack=0: mem_ce=1, mem_we=1, mem_addr=tape_addr, mem_d=tape_d. tape_ack=1.
  4. Otherwise: mem_ce=0, mem_we=0; mem_addr/mem_d hold their previous values; tape_ack=0.
- Read latency:
  - CPU request sampled at edge k appears on mem_* after edge k.
  - mem_q, and therefore cpu_q, is valid after edge k+1. CPU read latency is 2 clk.
- Tape handshake:
  - The requester samples tape_ack=1 and may then change tape_addr/tape_d, or drop tape_req, on the following cycle.
  - The arbiter never issues two tape writes on back-to-back edges (rule 3 requires tape_ack=0). Peak tape rate is one byte per 2 clk.
  - Simultaneous cpu_cs and tape_req: the CPU wins and the tape request waits with no loss.
  - Tape requests are never dropped or duplicated.
- Address equality between CPU and tape is not checked. Ordering is by grant order.
- Reset mid-operation: any in-flight tape request is forgotten. The requester must re-present it after clear_busy falls.

Test Plan:
- Reset release with AW=4, FILL=8'hFF -> 16 writes to addresses 0..15 with data FF on consecutive cycles; clear_busy falls after the 16th; subsequent CPU read of address 5 returns FF 2 clk after cpu_cs.
- SERVE: CPU write addr 0x1234 data 0x5A, then CPU read 0x1234 -> mem_we=1 on the first access, cpu_q=0x5A two edges after the read request.
- tape_req held with addr 0x0501 data 0xA5 while cpu_cs=1 for 5 cycles -> no tape_ack for those cycles; tape_ack pulses exactly once on the first cpu_cs=0 cycle; RAM[0x0501]=0xA5.
- Tape streams 4 bytes with cpu_cs=0 continuously -> writes issued on alternate edges, tape_ack exactly 4 pulses, data in RAM in order.
- clear_req pulse during SERVE while tape_req is pending -> CLEAR restarts at 0, no tape_ack until clear_busy=0, then the tape byte is written once.
- reset_n asserted mid-sweep (counter=7) -> outputs immediately at reset values; after release the sweep restarts from address 0.
